// File: rtl/alu_arb.sv
// alu_arb: two-requester front end for a single shared combinational ALU.
// A request is accepted in IDLE, its operands drive the ALU for one EXEC
// cycle, and the captured result is offered back in RESP until the granted
// requester takes it. Ties alternate based on the last grant.
// Optional feature: define ALU_ARB_STATS_EN to add per-requester accept
// counters grant_cnt0 / grant_cnt1 (CNT_W bits each, wrapping).
module alu_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic [2:0]       req0_op,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  input  logic [2:0]       req1_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [3:0]       alu_res,
  input  logic             alu_car,
  input  logic             alu_of,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [3:0]       rsp_res,
  output logic             rsp_car,
  output logic             rsp_of
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last_grant;
  logic        gnt_p0;
  logic [3:0]  a_p0;
  logic [3:0]  b_p0;
  logic [2:0]  op_p0;
  logic [3:0]  res_p1;
  logic        car_p1;
  logic        of_p1;
  logic [1:0]  vld_p1;
  logic [1:0]  ready;
  logic        acc;
  logic        acc_idx;

  // Arbitration: only in IDLE; on a tie the requester not granted last wins.
  always_comb begin
    ready = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   ready = 2'b01;
        2'b10:   ready = 2'b10;
        2'b11:   ready = last_grant ? 2'b01 : 2'b10;
        default: ready = 2'b00;
      endcase
    end
  end

  assign req_ready = ready;
  assign acc       = |(req_valid & ready);
  assign acc_idx   = ready[1];

  assign alu_a     = a_p0;
  assign alu_b     = b_p0;
  assign alu_ctrl  = op_p0;
  assign rsp_valid = vld_p1;
  assign rsp_res   = res_p1;
  assign rsp_car   = car_p1;
  assign rsp_of    = of_p1;

  // Control FSM with operand capture (stage p0) and result capture (stage p1).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_p0     <= 1'b0;
      a_p0       <= '0;
      b_p0       <= '0;
      op_p0      <= '0;
      res_p1     <= '0;
      car_p1     <= 1'b0;
      of_p1      <= 1'b0;
      vld_p1     <= 2'b00;
    end else begin
      case (state)
        // p0: latch the winner's operands; they feed the ALU during EXEC
        IDLE: begin
          if (acc) begin
            a_p0       <= acc_idx ? req1_a  : req0_a;
            b_p0       <= acc_idx ? req1_b  : req0_b;
            op_p0      <= acc_idx ? req1_op : req0_op;
            gnt_p0     <= acc_idx;
            last_grant <= acc_idx;
            state      <= EXEC;
          end
        end
        // p1: capture the ALU outputs untouched and flag the owner
        EXEC: begin
          res_p1 <= alu_res;
          car_p1 <= alu_car;
          of_p1  <= alu_of;
          vld_p1 <= gnt_p0 ? 2'b10 : 2'b01;
          state  <= RESP;
        end
        RESP: begin
          if (rsp_ready[gnt_p0]) begin
            vld_p1 <= 2'b00;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester accept counters, wrapping at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (acc) begin
      if (acc_idx) grant_cnt1 <= grant_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
      else         grant_cnt0 <= grant_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
